popgen_stream: RTL and testbench

POPGEN_STREAM -- requirements
Module: popgen_stream

---
 rtl/popgen_stream_if.sv | 24 ++
 rtl/popgen_stream.sv | 89 ++++++++
 tb/tb_popgen_stream.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/popgen_stream_if.sv
// Request/entry handshake bundle for popgen_stream; master drives requests, slave is the generator.
interface popgen_stream_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [CNT_W-1:0] out_count;
  logic             err;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_word, out_count, err
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, out_word, out_count, err
  );
endinterface

// File: rtl/popgen_stream.sv
// Builds words with k set bits (rotating offset when POPGEN_ROTATE_EN is defined) into a 2-entry FIFO.
// 1-cycle latency into an empty FIFO; in_ready drops only when both entries are held.
module popgen_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  popgen_stream_if.slave  bus
);
  localparam int OFF_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] K_MAX = CNT_W'(WIDTH);
  localparam logic [OFF_W:0]   SH_W  = (OFF_W+1)'(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] count;
  } ent_t;

  ent_t             mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       used;
  logic             err_q;
  logic [OFF_W-1:0] off;

  logic             push;
  logic             pop;
  logic             over;
  logic [CNT_W-1:0] k;
  logic [WIDTH-1:0] mask;
  logic [OFF_W:0]   rsh;
  logic [WIDTH-1:0] word;

  assign bus.in_ready  = (used != 2'd2);
  assign bus.out_valid = (used != 2'd0);
  assign bus.out_word  = mem[rd_ptr].word;
  assign bus.out_count = mem[rd_ptr].count;
  assign bus.err       = err_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Saturate, build an LSB-packed mask, then rotate it left by the current offset.
  always_comb begin
    over = (bus.in_count > K_MAX);
    k    = over ? K_MAX : bus.in_count;
    mask = (k == K_MAX) ? '1 : ((WIDTH'(1) << k) - WIDTH'(1));
    rsh  = SH_W - {1'b0, off};
    word = (mask << off) | (mask >> rsh);
  end

`ifdef POPGEN_ROTATE_EN
  localparam logic [CNT_W:0] WRAP = (CNT_W+1)'(WIDTH);
  logic [CNT_W:0] off_sum;

  assign off_sum = (CNT_W+1)'(off) + {1'b0, k};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off <= '0;
    end else if (push) begin
      off <= OFF_W'((off_sum >= WRAP) ? (off_sum - WRAP) : off_sum);
    end
  end
`else
  assign off = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      used   <= 2'd0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {word, k};
        wr_ptr      <= ~wr_ptr;
        if (over) err_q <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      used <= used + 2'd1;
      else if (pop && !push) used <= used - 2'd1;
    end
  end
endmodule

// File: tb/tb_popgen_stream.sv
// Randomized bench for popgen_stream with a queue-based reference model and hand-computed anchors.
module tb_popgen_stream;
  localparam int W  = 32;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;

  popgen_stream_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  popgen_stream #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    int           cnt;
  } ent_t;

  ent_t q[$];
  int   m_off = 0;
  bit   m_err = 1'b0;
  bit   rotate = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gen(input int k, input int off);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < k; i++) w[(off + i) % W] = 1'b1;
    return w;
  endfunction

  // Reference model: one transfer decision per rising edge, from the model's own occupancy.
  always @(posedge clk) begin
    if (!rst) begin
      bit pop;
      bit push;
      int k;
      pop  = (q.size() != 0) && bus.out_ready;
      push = bus.in_valid && (q.size() < 2);
      if (pop) void'(q.pop_front());
      if (push) begin
        k = (bus.in_count > W) ? W : int'(bus.in_count);
        if (bus.in_count > W) m_err = 1'b1;
        q.push_back('{gen(k, m_off), k});
        if (rotate) m_off = (m_off + k) % W;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("err", 64'(bus.err), 64'(m_err));
      if (q.size() != 0) begin
        chk("out_word", 64'(bus.out_word), 64'(q[0].word));
        chk("out_count", 64'(bus.out_count), 64'(q[0].cnt));
      end
    end
  end

  // Asynchronous reset pulse placed away from the clock edges; checked before any edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    q.delete();
    m_off = 0;
    m_err = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_word", 64'(bus.out_word), 64'd0);
    chk("rst_out_count", 64'(bus.out_count), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
`ifdef POPGEN_ROTATE_EN
    rotate = 1'b1;
`endif
    bus.in_valid  = 1'b0;
    bus.in_count  = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Requests 3 then 4
    @(negedge clk); bus.in_valid = 1'b1; bus.in_count = 6'd3;
    @(negedge clk);
    chk("a_word0", 64'(bus.out_word), 64'h7);
    chk("a_cnt0", 64'(bus.out_count), 64'd3);
    bus.in_count = 6'd4;
    @(negedge clk);
    chk("a_word1", 64'(bus.out_word), rotate ? 64'h78 : 64'hF);
    chk("a_cnt1", 64'(bus.out_count), 64'd4);
    bus.in_valid = 1'b0;

    // Requests 30, 5, 1: wrap then offset 3
    do_reset();
    @(negedge clk); bus.in_valid = 1'b1; bus.in_count = 6'd30;
    @(negedge clk);
    chk("b_word0", 64'(bus.out_word), 64'h3FFFFFFF);
    bus.in_count = 6'd5;
    @(negedge clk);
    chk("b_word1", 64'(bus.out_word), rotate ? 64'hC0000007 : 64'h1F);
    bus.in_count = 6'd1;
    @(negedge clk);
    chk("b_word2", 64'(bus.out_word), rotate ? 64'h8 : 64'h1);

    // Over-range request, sticky err, then k=0
    bus.in_count = 6'd40;
    @(negedge clk);
    chk("c_word", 64'(bus.out_word), 64'hFFFFFFFF);
    chk("c_cnt", 64'(bus.out_count), 64'd32);
    chk("c_err", 64'(bus.err), 64'd1);
    for (int i = 0; i < 10; i++) begin
      bus.in_count = 6'($urandom_range(0, W));
      @(negedge clk);
    end
    chk("c_err_sticky", 64'(bus.err), 64'd1);
    bus.in_count = 6'd0;
    @(negedge clk);
    chk("c_zero_word", 64'(bus.out_word), 64'd0);
    chk("c_zero_cnt", 64'(bus.out_count), 64'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Backpressure: third request held while both entries are full
    @(negedge clk); bus.in_valid = 1'b1; bus.in_count = 6'd2;
    @(negedge clk); bus.in_count = 6'd5;
    @(negedge clk); bus.in_count = 6'd9;
    @(negedge clk);
    chk("d_full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("d_head_cnt", 64'(bus.out_count), 64'd2);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("d_second_cnt", 64'(bus.out_count), 64'd5);
    @(negedge clk);
    chk("d_third_cnt", 64'(bus.out_count), 64'd9);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset with two entries held and err set
    bus.in_valid = 1'b1; bus.in_count = 6'd7;
    @(negedge clk); bus.in_count = 6'd1;
    @(negedge clk); bus.in_valid = 1'b0;
    chk("e_held_in_ready", 64'(bus.in_ready), 64'd0);
    chk("e_err_before", 64'(bus.err), 64'd1);
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_count = 6'd1;
    @(negedge clk);
    chk("e_after_word", 64'(bus.out_word), 64'h1);
    bus.in_valid = 1'b0;

    // Random traffic, with one mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) do_reset();
      bus.in_valid  = ($urandom % 3) != 0;
      if (!bus.in_valid)            bus.in_count = 6'($urandom);
      else if (($urandom % 8) == 0) bus.in_count = 6'($urandom_range(0, 63));
      else                          bus.in_count = 6'($urandom_range(0, W));
      bus.out_ready = ($urandom % 4) != 0;
    end

    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("drained", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
